candy_avb_desc_memory_dp: RTL and testbench

CANDY_AVB_DESC_MEMORY_DP -- requirements
Module: candy_avb_desc_memory_dp

---
 rtl/candy_avb_desc_memory_dp.sv | 197 +++++++++++++++++++
 tb/tb_candy_avb_desc_memory_dp.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/candy_avb_desc_memory_dp.sv
// Dual-port Avalon-MM descriptor memory with byte enables.
// Port s1 wins same-address write collisions; s2 is stalled for that cycle.
// An optional zero-fill sweep runs after every reset before commands are accepted.
// Read data comes from registered block-RAM reads, with one optional output stage.
module candy_avb_desc_memory_dp #(
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 2048,
   parameter int ADDR_W       = 11,
   parameter int READ_LATENCY = 1,
   parameter int INIT_ZERO    = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clken,
   input  logic                  reset_req,
   input  logic [ADDR_W-1:0]     s1_address,
   input  logic                  s1_chipselect,
   input  logic                  s1_read,
   input  logic                  s1_write,
   input  logic [DATA_W/8-1:0]   s1_byteenable,
   input  logic [DATA_W-1:0]     s1_writedata,
   output logic [DATA_W-1:0]     s1_readdata,
   output logic                  s1_readdatavalid,
   output logic                  s1_waitrequest,
   input  logic [ADDR_W-1:0]     s2_address,
   input  logic                  s2_chipselect,
   input  logic                  s2_read,
   input  logic                  s2_write,
   input  logic [DATA_W/8-1:0]   s2_byteenable,
   input  logic [DATA_W-1:0]     s2_writedata,
   output logic [DATA_W-1:0]     s2_readdata,
   output logic                  s2_readdatavalid,
   output logic                  s2_waitrequest,
   output logic                  init_busy
);

   localparam int                BE_W        = DATA_W / 8;
   localparam logic              INIT_ZERO_B = (INIT_ZERO != 0);
   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

   // Parameter legality is checked at elaboration so a bad configuration never simulates.
   if ((DATA_W < 8) || ((DATA_W % 8) != 0)) begin : g_bad_data_w
      $error("candy_avb_desc_memory_dp: DATA_W=%0d must be a positive multiple of 8", DATA_W);
   end
   if ((DEPTH < 2) || (ADDR_W != $clog2(DEPTH))) begin : g_bad_depth
      $error("candy_avb_desc_memory_dp: DEPTH=%0d / ADDR_W=%0d inconsistent", DEPTH, ADDR_W);
   end
   if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
      $error("candy_avb_desc_memory_dp: READ_LATENCY=%0d must be 1 or 2", READ_LATENCY);
   end

   typedef enum logic {CLEAR, READY} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;

   logic en;
   logic base_wait;
   logic collision;
   logic clr_we;
   logic s1_wr_acc, s2_wr_acc;

   // Port A of the RAM is shared by s1 and the zero-fill sweep (never active together).
   logic              pa_we;
   logic [ADDR_W-1:0] pa_addr;
   logic [BE_W-1:0]   pa_be;
   logic [DATA_W-1:0] pa_data;

   logic [1:0]             rd_acc;
   logic [1:0]             rd_valid;
   logic [1:0][DATA_W-1:0] rd_word;
   logic [1:0][DATA_W-1:0] rd_data;

   assign en        = clken & ~reset_req;
   assign init_busy = reset_n ? (state_reg == CLEAR) : INIT_ZERO_B;
   assign base_wait = ~reset_n | init_busy | ~en;
   assign collision = s1_chipselect & s1_write & s2_chipselect & s2_write
                    & (s1_address == s2_address);

   assign s1_waitrequest = base_wait;
   assign s2_waitrequest = base_wait | collision;

   // A read with write also high is treated as a pure write.
   assign s1_wr_acc = s1_chipselect & s1_write & ~s1_waitrequest;
   assign s2_wr_acc = s2_chipselect & s2_write & ~s2_waitrequest;
   assign rd_acc[0] = s1_chipselect & s1_read & ~s1_write & ~s1_waitrequest;
   assign rd_acc[1] = s2_chipselect & s2_read & ~s2_write & ~s2_waitrequest;

   assign clr_we  = reset_n & en & (state_reg == CLEAR);
   assign pa_we   = clr_we | s1_wr_acc;
   assign pa_addr = clr_we ? clr_cnt_reg : s1_address;
   assign pa_be   = clr_we ? {BE_W{1'b1}} : s1_byteenable;
   assign pa_data = clr_we ? '0 : s1_writedata;

   // State register and sweep counter; reset restarts the sweep from address 0.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg   <= INIT_ZERO_B ? CLEAR : READY;
         clr_cnt_reg <= '0;
      end else if (en) begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
      end
   end

   // Next state: step the sweep one address per enabled cycle, leave after the last one.
   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      case (state_reg)
         CLEAR: begin
            clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
            if (clr_cnt_reg == LAST_ADDR) begin
               state_next   = READY;
               clr_cnt_next = '0;
            end
         end
         default: begin
            state_next = READY;
         end
      endcase
   end

   genvar gi;

   // One RAM per byte lane so byte enables map onto plain per-lane write enables.
   for (gi = 0; gi < BE_W; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH];
      logic [7:0] q_a_reg, q_b_reg;

      // Lane writes from both ports; colliding addresses never reach here together.
      always_ff @(posedge clk) begin
         if (pa_we && pa_be[gi]) mem_lane[pa_addr] <= pa_data[gi*8 +: 8];
         if (s2_wr_acc && s2_byteenable[gi]) mem_lane[s2_address] <= s2_writedata[gi*8 +: 8];
      end

      // Port A registered read; a same-cycle write elsewhere yields the old byte.
      always_ff @(posedge clk) begin
         if (!reset_n)       q_a_reg <= '0;
         else if (rd_acc[0]) q_a_reg <= mem_lane[s1_address];
      end

      // Port B registered read.
      always_ff @(posedge clk) begin
         if (!reset_n)       q_b_reg <= '0;
         else if (rd_acc[1]) q_b_reg <= mem_lane[s2_address];
      end

      assign rd_word[0][gi*8 +: 8] = q_a_reg;
      assign rd_word[1][gi*8 +: 8] = q_b_reg;
   end

   // Per-port read pipeline: valid tracks data, everything freezes with en.
   for (gi = 0; gi < 2; gi++) begin : g_port
      logic              v1_reg;
      logic              v_out;
      logic [DATA_W-1:0] d_out;

      // First-stage valid, aligned with the RAM output register.
      always_ff @(posedge clk) begin
         if (!reset_n) v1_reg <= 1'b0;
         else if (en)  v1_reg <= rd_acc[gi];
      end

      if (READ_LATENCY == 2) begin : g_lat2
         logic              v2_reg;
         logic [DATA_W-1:0] d2_reg;

         // Second stage; data only moves with a valid so the output holds otherwise.
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               v2_reg <= 1'b0;
               d2_reg <= '0;
            end else if (en) begin
               v2_reg <= v1_reg;
               if (v1_reg) d2_reg <= rd_word[gi];
            end
         end

         assign v_out = v2_reg;
         assign d_out = d2_reg;
      end else begin : g_lat1
         assign v_out = v1_reg;
         assign d_out = rd_word[gi];
      end

      // A pending valid is only presented on a cycle that actually advances the pipe.
      assign rd_valid[gi] = v_out & en & reset_n;
      assign rd_data[gi]  = d_out;
   end

   assign s1_readdata      = rd_data[0];
   assign s1_readdatavalid = rd_valid[0];
   assign s2_readdata      = rd_data[1];
   assign s2_readdatavalid = rd_valid[1];

endmodule

// File: tb/tb_candy_avb_desc_memory_dp.sv
// Directed bench: two instances (read latency 1 and 2) share one stimulus stream.
// Read results are matched in order against hand-written expectation queues.
module tb_candy_avb_desc_memory_dp;

   logic        clk;
   logic        reset_n, clken, reset_req;
   logic [3:0]  s1_address, s2_address;
   logic        s1_chipselect, s1_read, s1_write;
   logic        s2_chipselect, s2_read, s2_write;
   logic [3:0]  s1_byteenable, s2_byteenable;
   logic [31:0] s1_writedata, s2_writedata;

   logic [31:0] o1_s1_rd, o1_s2_rd, o2_s1_rd, o2_s2_rd;
   logic        o1_s1_rdv, o1_s2_rdv, o2_s1_rdv, o2_s2_rdv;
   logic        o1_s1_wait, o1_s2_wait, o2_s1_wait, o2_s2_wait;
   logic        o1_busy, o2_busy;

   int n_checks = 0;
   int n_errors = 0;
   int n;

   // Expected read data per stream: q<latency><port>
   logic [31:0] q11[$], q12[$], q21[$], q22[$];

   candy_avb_desc_memory_dp #(
      .DATA_W(32), .DEPTH(16), .ADDR_W(4), .READ_LATENCY(1), .INIT_ZERO(1)
   ) u_lat1 (
      .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
      .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
      .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
      .s1_readdata(o1_s1_rd), .s1_readdatavalid(o1_s1_rdv), .s1_waitrequest(o1_s1_wait),
      .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
      .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
      .s2_readdata(o1_s2_rd), .s2_readdatavalid(o1_s2_rdv), .s2_waitrequest(o1_s2_wait),
      .init_busy(o1_busy)
   );

   candy_avb_desc_memory_dp #(
      .DATA_W(32), .DEPTH(16), .ADDR_W(4), .READ_LATENCY(2), .INIT_ZERO(1)
   ) u_lat2 (
      .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
      .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
      .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
      .s1_readdata(o2_s1_rd), .s1_readdatavalid(o2_s1_rdv), .s1_waitrequest(o2_s1_wait),
      .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
      .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
      .s2_readdata(o2_s2_rd), .s2_readdatavalid(o2_s2_rdv), .s2_waitrequest(o2_s2_wait),
      .init_busy(o2_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Any valid must match the oldest expected word of its stream.
   task automatic chk_rd(input int k, input logic v, input logic [31:0] d);
      logic [31:0] e;
      int sz;
      case (k)
         0:       sz = q11.size();
         1:       sz = q12.size();
         2:       sz = q21.size();
         default: sz = q22.size();
      endcase
      if (v !== 1'b0) begin
         n_checks++;
         assert ((v === 1'b1) && (sz > 0)) else begin
            n_errors++;
            $error("FAIL rdv_stream%0d observed valid=%b pending=%0d expected no valid", k, v, sz);
         end
         if ((v === 1'b1) && (sz > 0)) begin
            case (k)
               0:       e = q11.pop_front();
               1:       e = q12.pop_front();
               2:       e = q21.pop_front();
               default: e = q22.pop_front();
            endcase
            chk32($sformatf("rdata_stream%0d", k), d, e);
         end
      end
   endtask

   // Sample this cycle's read outputs, then move to 2 time units after the next edge.
   task automatic step();
      #2;
      chk_rd(0, o1_s1_rdv, o1_s1_rd);
      chk_rd(1, o1_s2_rdv, o1_s2_rd);
      chk_rd(2, o2_s1_rdv, o2_s1_rd);
      chk_rd(3, o2_s2_rdv, o2_s2_rd);
      @(posedge clk);
      #2;
   endtask

   task automatic drain();
      repeat (4) step();
      chk32("drain_l1_s1", 32'(q11.size()), 32'd0);
      chk32("drain_l1_s2", 32'(q12.size()), 32'd0);
      chk32("drain_l2_s1", 32'(q21.size()), 32'd0);
      chk32("drain_l2_s2", 32'(q22.size()), 32'd0);
   endtask

   task automatic idle();
      s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
      s1_address = 4'd0; s1_byteenable = 4'h0; s1_writedata = 32'h0;
      s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
      s2_address = 4'd0; s2_byteenable = 4'h0; s2_writedata = 32'h0;
   endtask

   task automatic rd1(input logic [3:0] a);
      s1_chipselect = 1'b1; s1_read = 1'b1; s1_write = 1'b0;
      s1_address = a; s1_byteenable = 4'h0; s1_writedata = 32'h0;
   endtask

   task automatic rd2(input logic [3:0] a);
      s2_chipselect = 1'b1; s2_read = 1'b1; s2_write = 1'b0;
      s2_address = a; s2_byteenable = 4'h0; s2_writedata = 32'h0;
   endtask

   task automatic wr1(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      s1_chipselect = 1'b1; s1_read = 1'b0; s1_write = 1'b1;
      s1_address = a; s1_byteenable = be; s1_writedata = d;
   endtask

   task automatic wr2(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      s2_chipselect = 1'b1; s2_read = 1'b0; s2_write = 1'b1;
      s2_address = a; s2_byteenable = be; s2_writedata = d;
   endtask

   // Count busy cycles after reset release; bounded so a stuck sweep still ends.
   task automatic count_sweep(input string tag);
      n = 0;
      #1;
      while ((o1_busy === 1'b1) && (n < 40)) begin
         n++;
         @(posedge clk);
         #3;
      end
      chk32(tag, 32'(n), 32'd16);
      chk1({tag, "_l2_done"}, o2_busy, 1'b0);
      chk1({tag, "_s1_wait"}, o1_s1_wait, 1'b0);
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
      idle();

      // Reset state
      repeat (3) @(posedge clk);
      #3;
      chk1("rst_busy_l1", o1_busy, 1'b1);
      chk1("rst_busy_l2", o2_busy, 1'b1);
      chk1("rst_wait_s1", o1_s1_wait, 1'b1);
      chk1("rst_wait_s2", o2_s2_wait, 1'b1);
      chk1("rst_rdv_l1", o1_s1_rdv, 1'b0);
      chk1("rst_rdv_l2", o2_s2_rdv, 1'b0);
      chk32("rst_rdata_l1", o1_s1_rd, 32'h0);
      chk32("rst_rdata_l2", o2_s1_rd, 32'h0);

      // Zero-fill sweep length, then every address reads zero
      reset_n = 1'b1;
      count_sweep("sweep_len");
      rd1(4'd0);
      #1;
      chk1("ready_wait_s1", o1_s1_wait, 1'b0);
      for (int i = 0; i < 16; i++) begin
         rd1(4'(i));
         q11.push_back(32'h0);
         q21.push_back(32'h0);
         step();
      end
      idle();
      drain();

      // Byte lanes, with read+write together treated as a write
      wr1(4'd5, 32'hAABBCCDD, 4'b1111);
      s1_read = 1'b1;
      #1;
      chk1("wr_wait_s1", o1_s1_wait, 1'b0);
      step();
      wr1(4'd5, 32'h11223344, 4'b0101);
      #1;
      chk1("rw_no_rdv_l1", o1_s1_rdv, 1'b0);
      step();
      idle();
      rd2(4'd5);
      q12.push_back(32'hAA22CC44);
      q22.push_back(32'hAA22CC44);
      #1;
      chk1("rw_no_rdv_l2", o2_s1_rdv, 1'b0);
      step();
      idle();
      #1;
      chk1("lat1_rdv_l1", o1_s2_rdv, 1'b1);
      chk1("lat1_rdv_l2", o2_s2_rdv, 1'b0);
      step();
      #1;
      chk1("lat2_rdv_l2", o2_s2_rdv, 1'b1);
      chk1("lat2_rdv_l1", o1_s2_rdv, 1'b0);
      chk32("hold_rdata_l1", o1_s2_rd, 32'hAA22CC44);
      step();
      drain();

      // Same-address collision stalls s2 one cycle; different addresses both land
      wr1(4'd7, 32'h1, 4'hF);
      wr2(4'd7, 32'h2, 4'hF);
      #1;
      chk1("coll_wait_s2_l1", o1_s2_wait, 1'b1);
      chk1("coll_wait_s2_l2", o2_s2_wait, 1'b1);
      chk1("coll_wait_s1", o1_s1_wait, 1'b0);
      step();
      idle();
      wr2(4'd7, 32'h2, 4'hF);
      #1;
      chk1("coll_retry_wait_s2", o1_s2_wait, 1'b0);
      step();
      wr1(4'd8, 32'h88, 4'hF);
      wr2(4'd9, 32'h99, 4'hF);
      #1;
      chk1("diff_addr_wait_s2", o1_s2_wait, 1'b0);
      step();
      idle();
      rd1(4'd7); q11.push_back(32'h2);  q21.push_back(32'h2);  step();
      rd1(4'd8); q11.push_back(32'h88); q21.push_back(32'h88); step();
      rd1(4'd9); q11.push_back(32'h99); q21.push_back(32'h99); step();
      idle();
      drain();

      // Mixed read-during-write returns old data, later read sees the new word
      wr1(4'd3, 32'h5, 4'hF);
      step();
      wr1(4'd3, 32'h9, 4'hF);
      rd2(4'd3);
      q12.push_back(32'h5); q22.push_back(32'h5);
      step();
      idle();
      rd2(4'd3);
      q12.push_back(32'h9); q22.push_back(32'h9);
      step();
      idle();
      drain();

      // Freeze during a back-to-back read burst
      rd1(4'd5); q11.push_back(32'hAA22CC44); q21.push_back(32'hAA22CC44); step();
      rd1(4'd7); q11.push_back(32'h2);        q21.push_back(32'h2);        step();
      reset_req = 1'b1;
      rd1(4'd3);
      #1;
      chk1("frz_wait_s1", o1_s1_wait, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk1($sformatf("frz_rdv_l1_c%0d", i), o1_s1_rdv, 1'b0);
         chk1($sformatf("frz_rdv_l2_c%0d", i), o2_s1_rdv, 1'b0);
         step();
      end
      reset_req = 1'b0;
      rd1(4'd3); q11.push_back(32'h9);  q21.push_back(32'h9);  step();
      rd1(4'd8); q11.push_back(32'h88); q21.push_back(32'h88); step();
      rd1(4'd9); q11.push_back(32'h99); q21.push_back(32'h99); step();
      idle();
      drain();
      chk32("hold_after_burst_l1", o1_s1_rd, 32'h99);
      chk32("hold_after_burst_l2", o2_s1_rd, 32'h99);

      // Reset with two reads in flight, then a reset in mid-sweep
      rd1(4'd5); q11.push_back(32'hAA22CC44); step();
      rd1(4'd7); step();
      idle();
      reset_n = 1'b0;
      #1;
      chk1("mid_rst_rdv_l1", o1_s1_rdv, 1'b0);
      chk1("mid_rst_rdv_l2", o2_s1_rdv, 1'b0);
      chk1("mid_rst_wait_s2", o1_s2_wait, 1'b1);
      step();
      #1;
      chk32("mid_rst_rdata_l1", o1_s1_rd, 32'h0);
      chk32("mid_rst_rdata_l2", o2_s1_rd, 32'h0);
      chk1("mid_rst_busy_l2", o2_busy, 1'b1);
      chk1("mid_rst_rdv2_l2", o2_s1_rdv, 1'b0);
      step();
      reset_n = 1'b1;
      repeat (5) step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      count_sweep("resweep_len");
      rd1(4'd5); q11.push_back(32'h0); q21.push_back(32'h0); step();
      rd1(4'd7); q11.push_back(32'h0); q21.push_back(32'h0); step();
      idle();
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute time bound in case the DUT wedges the sequence.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
